// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM bill dispense scheduler.
// Denomination weights are expressed in $10 units, indexed by bin.
package atm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PLAN,
    DISP,
    GAPW,
    DONE,
    ERR
  } state_t;

  localparam int NUM_BINS = 4;

  localparam logic [1:0] BIN_100 = 2'd0;
  localparam logic [1:0] BIN_50  = 2'd1;
  localparam logic [1:0] BIN_20  = 2'd2;
  localparam logic [1:0] BIN_10  = 2'd3;

  localparam logic [3:0] DENOM_W [NUM_BINS] = '{4'd10, 4'd5, 4'd2, 4'd1};

endpackage

// File: rtl/atm_bin_inventory.sv
// Four per-bin bill counters with an overwrite load port, a single-bill
// decrement port and a combinational read of every count.
module atm_bin_inventory
  import atm_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [1:0]       load_bin,
  input  logic [CNT_W-1:0] load_cnt,
  input  logic             dec_en,
  input  logic [1:0]       dec_bin,
  output logic [CNT_W-1:0] counts [NUM_BINS]
);

  // NOTE: this is a register file, not a RAM; it is reset so a cold cassette reads empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BINS; i++) counts[i] <= '0;
    end else if (load_en) begin
      counts[load_bin] <= load_cnt;
    end else if (dec_en) begin
      counts[dec_bin] <= counts[dec_bin] - CNT_W'(1);
    end
  end

endmodule

// File: rtl/atm_dispense_sched.sv
// Plans a greedy bill breakdown for a withdrawal, then sequences the 1-to-4
// demux with one fire pulse per bill, spaced by GAP idle cycles.
module atm_dispense_sched
  import atm_pkg::*;
#(
  parameter int AMT_W = 10,
  parameter int CNT_W = 8,
  parameter int GAP   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [AMT_W-1:0] amount,
  input  logic             load_en,
  input  logic [1:0]       load_bin,
  input  logic [CNT_W-1:0] load_cnt,
  output logic [1:0]       sel,
  output logic             fire,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int GAP_W = $clog2(GAP + 1);

  state_t           state;
  logic [AMT_W-1:0] rem;
  logic [1:0]       bin;
  logic [CNT_W-1:0] plan [NUM_BINS];
  logic [GAP_W-1:0] gap_cnt;
  logic [CNT_W-1:0] inv  [NUM_BINS];

  logic [AMT_W-1:0] w_cur;
  logic             take;
  logic             dec_en;
  logic             inv_load;

  assign w_cur    = AMT_W'(DENOM_W[bin]);
  assign take     = (rem >= w_cur) && (plan[bin] < inv[bin]);
  assign dec_en   = (state == DISP) && (plan[bin] != '0);
  assign inv_load = load_en && (state == IDLE);

  atm_bin_inventory #(.CNT_W(CNT_W)) u_inv (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (inv_load),
    .load_bin (load_bin),
    .load_cnt (load_cnt),
    .dec_en   (dec_en),
    .dec_bin  (bin),
    .counts   (inv)
  );

  // NOTE: all state and outputs use <= so every branch sees last cycle's values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      rem     <= '0;
      bin     <= BIN_100;
      gap_cnt <= '0;
      for (int i = 0; i < NUM_BINS; i++) plan[i] <= '0;
      sel     <= '0;
      fire    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      fire <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (!load_en && req) begin
            rem   <= amount;
            for (int i = 0; i < NUM_BINS; i++) plan[i] <= '0;
            bin   <= BIN_100;
            state <= PLAN;
            busy  <= 1'b1;
          end
        end
        PLAN: begin
          if (take) begin
            plan[bin] <= plan[bin] + CNT_W'(1);
            rem       <= rem - w_cur;
          end else if (bin != BIN_10) begin
            bin <= bin + 2'd1;
          end else if (rem == '0) begin
            bin   <= BIN_100;
            state <= DISP;
          end else begin
            state <= ERR;
            err   <= 1'b1;
          end
        end
        DISP: begin
          if (plan[bin] == '0) begin
            if (bin == BIN_10) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              bin <= bin + 2'd1;
            end
          end else begin
            fire      <= 1'b1;
            sel       <= bin;
            plan[bin] <= plan[bin] - CNT_W'(1);
            gap_cnt   <= GAP_W'(GAP);
            state     <= GAPW;
          end
        end
        GAPW: begin
          if (gap_cnt <= GAP_W'(1)) state <= DISP;
          else                      gap_cnt <= gap_cnt - GAP_W'(1);
        end
        default: begin
          // DONE and ERR last one cycle; their pulses were raised on entry.
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_atm_dispense_sched.sv
// Self-checking bench for atm_dispense_sched: directed test-plan scenarios
// plus randomized withdrawals checked against an arithmetic greedy model.
module tb_atm_dispense_sched;

  localparam int AMT_W = 10;
  localparam int CNT_W = 8;
  localparam int GAP   = 3;

  typedef int arr4_t[4];
  typedef int q_t[$];

  logic             clk;
  logic             rst_n;
  logic             req;
  logic [AMT_W-1:0] amount;
  logic             load_en;
  logic [1:0]       load_bin;
  logic [CNT_W-1:0] load_cnt;
  logic [1:0]       sel;
  logic             fire;
  logic             busy;
  logic             done;
  logic             err;

  int vectors;
  int miscompares;

  int    wt[4] = '{10, 5, 2, 1};
  arr4_t m_inv;
  arr4_t m_plan;

  int obs_sel[$];
  int obs_t[$];
  bit obs_done;
  bit obs_err;

  atm_dispense_sched #(.AMT_W(AMT_W), .CNT_W(CNT_W), .GAP(GAP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .amount   (amount),
    .load_en  (load_en),
    .load_bin (load_bin),
    .load_cnt (load_cnt),
    .sel      (sel),
    .fire     (fire),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Greedy breakdown: take as many of each bill as the amount and stock allow.
  function automatic bit model_greedy(input int amt);
    int r;
    r = amt;
    for (int b = 0; b < 4; b++) begin
      int n;
      n = r / wt[b];
      if (n > m_inv[b]) n = m_inv[b];
      m_plan[b] = n;
      r -= n * wt[b];
    end
    return (r == 0);
  endfunction

  task automatic load_inv(input int b, input int c);
    @(negedge clk);
    load_en  = 1'b1;
    load_bin = 2'(b);
    load_cnt = CNT_W'(c);
    @(negedge clk);
    load_en  = 1'b0;
    m_inv[b] = c;
  endtask

  task automatic load_all(input arr4_t v);
    for (int b = 0; b < 4; b++) load_inv(b, v[b]);
  endtask

  // Collects fire pulses and the final done/err until the transaction ends.
  task automatic monitor_txn();
    bit ended;
    ended    = 1'b0;
    obs_sel  = {};
    obs_t    = {};
    obs_done = 1'b0;
    obs_err  = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (fire) begin
        obs_sel.push_back(int'(sel));
        obs_t.push_back(i);
      end
      if (busy) req = 1'b0;
      if (done || err) begin
        obs_done = done;
        obs_err  = err;
        ended    = 1'b1;
        break;
      end
    end
    if (!ended) begin
      vectors++;
      miscompares++;
      $display("FAIL txn_timeout: got no done/err, expected one within 3000 cycles");
    end
    req = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_txn(input int amt);
    @(negedge clk);
    req    = 1'b1;
    amount = AMT_W'(amt);
    monitor_txn();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors += 5;
    if (sel !== 2'd0) begin miscompares++; $display("FAIL reset_sel: got %0d expected 0", sel); end
    if (fire !== 1'b0) begin miscompares++; $display("FAIL reset_fire: got %0b expected 0", fire); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %0b expected 0", done); end
    if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %0b expected 0", err); end
    for (int b = 0; b < 4; b++) begin
      vectors++;
      if (dut.u_inv.counts[b] !== CNT_W'(0)) begin
        miscompares++;
        $display("FAIL reset_inv%0d: got %0d expected 0", b, dut.u_inv.counts[b]);
      end
    end
    rst_n = 1'b1;
    for (int b = 0; b < 4; b++) m_inv[b] = 0;
  endtask

  // Directed transaction against hand-derived expectations.
  task automatic test_directed(input string name, input arr4_t ld, input int amt,
                               input bit exp_ok, input q_t exp_sel, input arr4_t exp_inv);
    int n;
    load_all(ld);
    run_txn(amt);
    vectors++;
    if ({obs_done, obs_err} !== {exp_ok, !exp_ok}) begin
      miscompares++;
      $display("FAIL %s_outcome: got done=%0b err=%0b expected done=%0b err=%0b",
               name, obs_done, obs_err, exp_ok, !exp_ok);
    end
    vectors++;
    if (obs_sel.size() !== exp_sel.size()) begin
      miscompares++;
      $display("FAIL %s_fires: got %0d expected %0d", name, obs_sel.size(), exp_sel.size());
    end
    n = (obs_sel.size() < exp_sel.size()) ? obs_sel.size() : exp_sel.size();
    for (int k = 0; k < n; k++) begin
      vectors++;
      if (obs_sel[k] !== exp_sel[k]) begin
        miscompares++;
        $display("FAIL %s_sel%0d: got %0d expected %0d", name, k, obs_sel[k], exp_sel[k]);
      end
      if (k > 0) begin
        vectors++;
        if (obs_t[k] - obs_t[k-1] !== GAP + 1 + exp_sel[k] - exp_sel[k-1]) begin
          miscompares++;
          $display("FAIL %s_spacing%0d: got %0d expected %0d", name, k,
                   obs_t[k] - obs_t[k-1], GAP + 1 + exp_sel[k] - exp_sel[k-1]);
        end
      end
    end
    for (int b = 0; b < 4; b++) begin
      vectors++;
      if (int'(dut.u_inv.counts[b]) !== exp_inv[b]) begin
        miscompares++;
        $display("FAIL %s_inv%0d: got %0d expected %0d", name, b, dut.u_inv.counts[b], exp_inv[b]);
      end
      m_inv[b] = exp_inv[b];
    end
  endtask

  task automatic test_load_and_req();
    load_all('{0, 0, 0, 0});
    @(negedge clk);
    load_en  = 1'b1;
    load_bin = 2'd3;
    load_cnt = CNT_W'(5);
    req      = 1'b1;
    amount   = AMT_W'(1);
    @(negedge clk);
    m_inv[3] = 5;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL loadreq_nostart: got busy=%0b expected 0", busy); end
    load_en = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL loadreq_start: got busy=%0b expected 1", busy); end
    monitor_txn();
    vectors += 3;
    if (obs_done !== 1'b1) begin miscompares++; $display("FAIL loadreq_done: got %0b expected 1", obs_done); end
    if (obs_sel.size() !== 1 || (obs_sel.size() == 1 && obs_sel[0] !== 3)) begin
      miscompares++;
      $display("FAIL loadreq_fire: got %0d fires expected 1 fire on sel 3", obs_sel.size());
    end
    if (dut.u_inv.counts[3] !== CNT_W'(4)) begin
      miscompares++;
      $display("FAIL loadreq_inv3: got %0d expected 4", dut.u_inv.counts[3]);
    end
    m_inv[3] = 4;
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    load_all('{2, 1, 3, 5});
    @(negedge clk);
    req    = 1'b1;
    amount = AMT_W'(30);
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (busy) req = 1'b0;
      if (fire) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL rstmid_fire: got no fire expected one before reset"); end
    rst_n = 1'b0;
    @(negedge clk);
    vectors += 5;
    if (sel !== 2'd0) begin miscompares++; $display("FAIL rstmid_sel: got %0d expected 0", sel); end
    if (fire !== 1'b0) begin miscompares++; $display("FAIL rstmid_fire_low: got %0b expected 0", fire); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %0b expected 0", busy); end
    if (done !== 1'b0) begin miscompares++; $display("FAIL rstmid_done: got %0b expected 0", done); end
    if (err !== 1'b0) begin miscompares++; $display("FAIL rstmid_err: got %0b expected 0", err); end
    for (int b = 0; b < 4; b++) begin
      vectors++;
      if (dut.u_inv.counts[b] !== CNT_W'(0)) begin
        miscompares++;
        $display("FAIL rstmid_inv%0d: got %0d expected 0", b, dut.u_inv.counts[b]);
      end
      m_inv[b] = 0;
    end
    rst_n = 1'b1;
    run_txn(1);
    vectors += 2;
    if (obs_err !== 1'b1 || obs_done !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_after: got done=%0b err=%0b expected done=0 err=1", obs_done, obs_err);
    end
    if (obs_sel.size() !== 0) begin
      miscompares++;
      $display("FAIL rstmid_after_fires: got %0d expected 0", obs_sel.size());
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 25; t++) begin
      arr4_t ld;
      int    amt;
      bit    ok;
      int    exp_sel[$];
      for (int b = 0; b < 4; b++) ld[b] = int'($urandom_range(0, 6));
      load_all(ld);
      amt = int'($urandom_range(0, 40));
      ok  = model_greedy(amt);
      exp_sel = {};
      if (ok) for (int b = 0; b < 4; b++) repeat (m_plan[b]) exp_sel.push_back(b);
      run_txn(amt);
      vectors++;
      if ({obs_done, obs_err} !== {ok, !ok}) begin
        miscompares++;
        $display("FAIL rand%0d_outcome amt=%0d: got done=%0b err=%0b expected done=%0b err=%0b",
                 t, amt, obs_done, obs_err, ok, !ok);
      end
      vectors++;
      if (obs_sel.size() !== exp_sel.size()) begin
        miscompares++;
        $display("FAIL rand%0d_fires amt=%0d: got %0d expected %0d", t, amt, obs_sel.size(), exp_sel.size());
      end else begin
        for (int k = 0; k < exp_sel.size(); k++) begin
          vectors++;
          if (obs_sel[k] !== exp_sel[k] ||
              (k > 0 && obs_t[k] - obs_t[k-1] !== GAP + 1 + exp_sel[k] - exp_sel[k-1])) begin
            miscompares++;
            $display("FAIL rand%0d_bill%0d: got sel=%0d expected sel=%0d", t, k, obs_sel[k], exp_sel[k]);
          end
        end
      end
      if (ok) for (int b = 0; b < 4; b++) m_inv[b] -= m_plan[b];
      for (int b = 0; b < 4; b++) begin
        vectors++;
        if (int'(dut.u_inv.counts[b]) !== m_inv[b]) begin
          miscompares++;
          $display("FAIL rand%0d_inv%0d: got %0d expected %0d", t, b, dut.u_inv.counts[b], m_inv[b]);
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    req         = 1'b0;
    amount      = '0;
    load_en     = 1'b0;
    load_bin    = '0;
    load_cnt    = '0;
    test_reset();
    test_directed("amt180", '{2, 1, 3, 5}, 18, 1'b1, '{0, 1, 2, 3}, '{1, 0, 2, 4});
    test_directed("amt300", '{2, 1, 3, 5}, 30, 1'b1, '{0, 0, 1, 2, 2, 3}, '{0, 0, 1, 4});
    test_directed("nongreedy", '{0, 1, 3, 0}, 6, 1'b0, '{}, '{0, 1, 3, 0});
    test_directed("zero", '{3, 2, 1, 4}, 0, 1'b1, '{}, '{3, 2, 1, 4});
    test_load_and_req();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
